// File: rtl/wish_pack_flex_if.sv
`default_nettype none
// ============================================================================
// wish_pack_flex_if : source/destination Wishbone stream bundle for the packer
// Rev 1.0
// ============================================================================
interface wish_pack_flex_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_PACK   = 4,
  parameter int TGC_WIDTH  = 2
);
  localparam int CNT_WIDTH = $clog2(NUM_PACK + 1);

  logic                           s_stb_i;
  logic                           s_cyc_i;
  logic                           s_ack_o;
  logic                           s_stall_o;
  logic [DATA_WIDTH-1:0]          s_dat_i;
  logic [TGC_WIDTH-1:0]           s_tgc_i;
  logic                           s_last_i;
  logic                           d_stb_o;
  logic                           d_cyc_o;
  logic                           d_ack_i;
  logic [DATA_WIDTH*NUM_PACK-1:0] d_dat_o;
  logic [TGC_WIDTH-1:0]           d_tgc_o;
  logic [NUM_PACK-1:0]            d_sel_o;
  logic [CNT_WIDTH-1:0]           d_cnt_o;

  // slave is the packer's own view; master is whatever surrounds it
  modport slave (
    input  s_stb_i, s_cyc_i, s_dat_i, s_tgc_i, s_last_i, d_ack_i,
    output s_ack_o, s_stall_o, d_stb_o, d_cyc_o, d_dat_o, d_tgc_o, d_sel_o, d_cnt_o
  );

  modport master (
    output s_stb_i, s_cyc_i, s_dat_i, s_tgc_i, s_last_i, d_ack_i,
    input  s_ack_o, s_stall_o, d_stb_o, d_cyc_o, d_dat_o, d_tgc_o, d_sel_o, d_cnt_o
  );
endinterface

`default_nettype wire

// File: rtl/wish_pack_flex.sv
`default_nettype none
// ============================================================================
// wish_pack_flex : packs narrow Wishbone beats into wide words with early flush
// Rev 1.0
// ============================================================================
module wish_pack_flex #(
  parameter int DATA_WIDTH       = 8,
  parameter int NUM_PACK         = 4,
  parameter int TGC_WIDTH        = 2,
  parameter int LITTLE_ENDIAN    = 1,
  parameter int FLUSH_ON_CYC_END = 1
) (
  input  wire logic          clk_i,
  input  wire logic          rst_i,
  wish_pack_flex_if.slave    bus
);
  localparam int CNT_WIDTH  = $clog2(NUM_PACK + 1);
  localparam int WORD_WIDTH = DATA_WIDTH * NUM_PACK;
  localparam logic [CNT_WIDTH-1:0] LAST_SLOT = CNT_WIDTH'(NUM_PACK - 1);

  logic [CNT_WIDTH-1:0]  cnt;
  logic [WORD_WIDTH-1:0] acc_dat;
  logic [TGC_WIDTH-1:0]  acc_tgc;
  logic [NUM_PACK-1:0]   acc_sel;

  logic                  out_valid;
  logic [WORD_WIDTH-1:0] out_dat;
  logic [TGC_WIDTH-1:0]  out_tgc;
  logic [NUM_PACK-1:0]   out_sel;
  logic [CNT_WIDTH-1:0]  out_cnt;

  logic                  closes;
  logic                  out_free;
  logic                  stall;
  logic                  accept;
  logic                  complete;
  logic                  flush;
  logic [WORD_WIDTH-1:0] beat_dat;
  logic [NUM_PACK-1:0]   beat_sel;
  logic [TGC_WIDTH-1:0]  merged_tgc;

  // Only a beat that would close a word needs the output register free.
  assign closes   = (cnt == LAST_SLOT) | bus.s_last_i;
  assign out_free = ~out_valid | bus.d_ack_i;
  assign stall    = rst_i | (~out_free & closes);
  assign accept   = bus.s_stb_i & bus.s_cyc_i & ~stall & ~rst_i;
  assign complete = accept & closes;
  assign flush    = (FLUSH_ON_CYC_END != 0) & ~bus.s_cyc_i & (cnt != '0)
                  & out_free & ~rst_i;

  always_comb begin
    beat_dat = '0;
    beat_sel = '0;
    for (int lane = 0; lane < NUM_PACK; lane++) begin
      if (CNT_WIDTH'((LITTLE_ENDIAN != 0) ? lane : NUM_PACK - 1 - lane) == cnt) begin
        beat_dat[lane*DATA_WIDTH +: DATA_WIDTH] = bus.s_dat_i;
        beat_sel[lane] = 1'b1;
      end
    end
  end

  assign merged_tgc = (cnt == '0) ? bus.s_tgc_i : (acc_tgc | bus.s_tgc_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt       <= '0;
      acc_dat   <= '0;
      acc_tgc   <= '0;
      acc_sel   <= '0;
      out_valid <= 1'b0;
      out_dat   <= '0;
      out_tgc   <= '0;
      out_sel   <= '0;
      out_cnt   <= '0;
    end else if (complete) begin
      out_valid <= 1'b1;
      out_dat   <= acc_dat | beat_dat;
      out_tgc   <= merged_tgc;
      out_sel   <= acc_sel | beat_sel;
      out_cnt   <= cnt + CNT_WIDTH'(1);
      cnt       <= '0;
      acc_dat   <= '0;
      acc_tgc   <= '0;
      acc_sel   <= '0;
    end else if (flush) begin
      out_valid <= 1'b1;
      out_dat   <= acc_dat;
      out_tgc   <= acc_tgc;
      out_sel   <= acc_sel;
      out_cnt   <= cnt;
      cnt       <= '0;
      acc_dat   <= '0;
      acc_tgc   <= '0;
      acc_sel   <= '0;
    end else begin
      if (accept) begin
        acc_dat <= acc_dat | beat_dat;
        acc_tgc <= merged_tgc;
        acc_sel <= acc_sel | beat_sel;
        cnt     <= cnt + CNT_WIDTH'(1);
      end
      // Output fields stay as they were; only the valid flag drops on ack.
      if (out_valid && bus.d_ack_i) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign bus.s_ack_o   = accept;
  assign bus.s_stall_o = stall;
  assign bus.d_stb_o   = out_valid;
  assign bus.d_cyc_o   = out_valid;
  assign bus.d_dat_o   = out_dat;
  assign bus.d_tgc_o   = out_tgc;
  assign bus.d_sel_o   = out_sel;
  assign bus.d_cnt_o   = out_cnt;
endmodule

`default_nettype wire

// File: tb/tb_wish_pack_flex.sv
`default_nettype none
// ============================================================================
// tb_wish_pack_flex : three packer variants (LE, BE, no cycle-end flush) driven
// by one directed stimulus stream and checked against a beat-list model
// Rev 1.0
// ============================================================================
module tb_wish_pack_flex;
  localparam int DW = 8;
  localparam int NP = 4;
  localparam int TW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, stb, cyc, last, dack;
  logic [DW-1:0] dat;
  logic [TW-1:0] tgc;

  int tests = 0;
  int fails = 0;

  wish_pack_flex_if #(.DATA_WIDTH(DW), .NUM_PACK(NP), .TGC_WIDTH(TW)) ifa ();
  wish_pack_flex_if #(.DATA_WIDTH(DW), .NUM_PACK(NP), .TGC_WIDTH(TW)) ifb ();
  wish_pack_flex_if #(.DATA_WIDTH(DW), .NUM_PACK(NP), .TGC_WIDTH(TW)) ifc ();

  assign ifa.s_stb_i = stb;  assign ifb.s_stb_i = stb;  assign ifc.s_stb_i = stb;
  assign ifa.s_cyc_i = cyc;  assign ifb.s_cyc_i = cyc;  assign ifc.s_cyc_i = cyc;
  assign ifa.s_dat_i = dat;  assign ifb.s_dat_i = dat;  assign ifc.s_dat_i = dat;
  assign ifa.s_tgc_i = tgc;  assign ifb.s_tgc_i = tgc;  assign ifc.s_tgc_i = tgc;
  assign ifa.s_last_i = last; assign ifb.s_last_i = last; assign ifc.s_last_i = last;
  assign ifa.d_ack_i = dack; assign ifb.d_ack_i = dack; assign ifc.d_ack_i = dack;

  wish_pack_flex #(.DATA_WIDTH(DW), .NUM_PACK(NP), .TGC_WIDTH(TW),
                   .LITTLE_ENDIAN(1), .FLUSH_ON_CYC_END(1))
    dut_le (.clk_i(clk), .rst_i(rst), .bus(ifa));
  wish_pack_flex #(.DATA_WIDTH(DW), .NUM_PACK(NP), .TGC_WIDTH(TW),
                   .LITTLE_ENDIAN(0), .FLUSH_ON_CYC_END(1))
    dut_be (.clk_i(clk), .rst_i(rst), .bus(ifb));
  wish_pack_flex #(.DATA_WIDTH(DW), .NUM_PACK(NP), .TGC_WIDTH(TW),
                   .LITTLE_ENDIAN(1), .FLUSH_ON_CYC_END(0))
    dut_nf (.clk_i(clk), .rst_i(rst), .bus(ifc));

  // Model: list of beats gathered so far plus the word currently offered.
  typedef struct packed {
    bit              ov;
    bit              zero;
    logic [31:0]     od;
    logic [1:0]      ot;
    logic [3:0]      os;
    logic [2:0]      oc;
    int              n;
    logic [3:0][7:0] bd;
    logic [3:0][1:0] bt;
  } mdl_t;

  mdl_t ma = '0, mb = '0, mc = '0;
  bit   started = 1'b0;

  function automatic bit m_stall(mdl_t m);
    bit closes, free;
    closes = (m.n == NP - 1) || last;
    free   = !m.ov || dack;
    return rst || (!free && closes);
  endfunction

  function automatic bit m_ack(mdl_t m);
    return !rst && stb && cyc && !m_stall(m);
  endfunction

  function automatic mdl_t m_emit(mdl_t m, bit le);
    int lane;
    m.od = '0; m.ot = '0; m.os = '0;
    for (int k = 0; k < NP; k++) begin
      if (k < m.n) begin
        lane = le ? k : NP - 1 - k;
        m.od = m.od | (32'(m.bd[k]) << (8 * lane));
        m.ot = m.ot | m.bt[k];
        m.os[lane] = 1'b1;
      end
    end
    m.oc = 3'(m.n);
    m.ov = 1'b1;
    m.zero = 1'b0;
    m.n = 0;
    return m;
  endfunction

  function automatic mdl_t m_step(mdl_t m, bit le, bit fce);
    bit acc, free;
    if (rst) begin
      m = '0;
      m.zero = 1'b1;
      return m;
    end
    acc  = m_ack(m);
    free = !m.ov || dack;
    if (acc) begin
      m.bd[m.n] = dat;
      m.bt[m.n] = tgc;
      m.n = m.n + 1;
    end
    if (acc && (m.n == NP || last)) m = m_emit(m, le);
    else if (fce && !cyc && m.n > 0 && free) m = m_emit(m, le);
    else if (m.ov && dack) m.ov = 1'b0;
    return m;
  endfunction

  always @(posedge clk) begin
    ma <= m_step(ma, 1'b1, 1'b1);
    mb <= m_step(mb, 1'b0, 1'b1);
    mc <= m_step(mc, 1'b1, 1'b0);
    if (rst) started <= 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input string nm, input mdl_t m, input logic a, input logic s,
                     input logic v, input logic c, input logic [31:0] d,
                     input logic [1:0] t, input logic [3:0] se, input logic [2:0] cn);
    check({nm, "_ack"},   32'(a), 32'(m_ack(m)));
    check({nm, "_stall"}, 32'(s), 32'(m_stall(m)));
    check({nm, "_stb"},   32'(v), 32'(m.ov));
    check({nm, "_cyc"},   32'(c), 32'(m.ov));
    if (m.ov || m.zero) begin
      check({nm, "_dat"}, d, m.od);
      check({nm, "_tgc"}, 32'(t), 32'(m.ot));
      check({nm, "_sel"}, 32'(se), 32'(m.os));
      check({nm, "_cnt"}, 32'(cn), 32'(m.oc));
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      cmp("le", ma, ifa.s_ack_o, ifa.s_stall_o, ifa.d_stb_o, ifa.d_cyc_o,
          ifa.d_dat_o, ifa.d_tgc_o, ifa.d_sel_o, ifa.d_cnt_o);
      cmp("be", mb, ifb.s_ack_o, ifb.s_stall_o, ifb.d_stb_o, ifb.d_cyc_o,
          ifb.d_dat_o, ifb.d_tgc_o, ifb.d_sel_o, ifb.d_cnt_o);
      cmp("nf", mc, ifc.s_ack_o, ifc.s_stall_o, ifc.d_stb_o, ifc.d_cyc_o,
          ifc.d_dat_o, ifc.d_tgc_o, ifc.d_sel_o, ifc.d_cnt_o);
    end
  end

  task automatic beat(input logic [7:0] d, input logic [1:0] t, input logic l);
    stb = 1'b1; cyc = 1'b1; dat = d; tgc = t; last = l;
    @(posedge clk); #1;
    stb = 1'b0; last = 1'b0;
  endtask

  task automatic idle(input int n);
    stb = 1'b0; last = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    rst = 1'b1; stb = 1'b0; cyc = 1'b0; last = 1'b0; dack = 1'b1;
    dat = '0; tgc = '0;
    @(negedge clk);
    check("rst_stall", 32'(ifa.s_stall_o), 32'h1);
    check("rst_ack", 32'(ifa.s_ack_o), 32'h0);
    check("rst_stb", 32'(ifa.d_stb_o), 32'h0);
    check("rst_dat", ifa.d_dat_o, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; cyc = 1'b1;

    // full word, both lane orders
    beat(8'h11, 2'b01, 1'b0); beat(8'h22, 2'b00, 1'b0);
    beat(8'h33, 2'b10, 1'b0); beat(8'h44, 2'b00, 1'b0);
    @(negedge clk);
    check("full_le_dat", ifa.d_dat_o, 32'h44332211);
    check("full_le_tgc", 32'(ifa.d_tgc_o), 32'h3);
    check("full_le_sel", 32'(ifa.d_sel_o), 32'hF);
    check("full_le_cnt", 32'(ifa.d_cnt_o), 32'h4);
    check("full_be_dat", ifb.d_dat_o, 32'h11223344);
    idle(1);

    // early flush on last, then a fresh word starts in lane 0
    beat(8'hAA, 2'b00, 1'b0); beat(8'hBB, 2'b00, 1'b1);
    @(negedge clk);
    check("early_le_dat", ifa.d_dat_o, 32'h0000BBAA);
    check("early_le_sel", 32'(ifa.d_sel_o), 32'h3);
    check("early_le_cnt", 32'(ifa.d_cnt_o), 32'h2);
    check("early_be_dat", ifb.d_dat_o, 32'hAABB0000);
    beat(8'hCC, 2'b00, 1'b1);
    @(negedge clk);
    check("restart_dat", ifa.d_dat_o, 32'h000000CC);
    check("restart_sel", 32'(ifa.d_sel_o), 32'h1);
    idle(1);

    // backpressure: 8th beat must wait for the destination
    dack = 1'b0;
    beat(8'h11, 2'b00, 1'b0); beat(8'h22, 2'b00, 1'b0);
    beat(8'h33, 2'b00, 1'b0); beat(8'h44, 2'b00, 1'b0);
    beat(8'h55, 2'b00, 1'b0); beat(8'h66, 2'b00, 1'b0);
    beat(8'h77, 2'b00, 1'b0);
    stb = 1'b1; dat = 8'h88; tgc = 2'b00;
    repeat (3) begin
      @(negedge clk);
      check("bp_stall", 32'(ifa.s_stall_o), 32'h1);
      check("bp_ack", 32'(ifa.s_ack_o), 32'h0);
      check("bp_hold_dat", ifa.d_dat_o, 32'h44332211);
      @(posedge clk); #1;
    end
    dack = 1'b1;
    @(negedge clk);
    check("bp_release_ack", 32'(ifa.s_ack_o), 32'h1);
    @(posedge clk); #1;
    stb = 1'b0; dack = 1'b0;
    @(negedge clk);
    check("bp_word2_dat", ifa.d_dat_o, 32'h88776655);
    check("bp_word2_stb", 32'(ifa.d_stb_o), 32'h1);
    dack = 1'b1;
    idle(2);

    // cycle end flushes a partial word only where enabled
    beat(8'h11, 2'b00, 1'b0); beat(8'h22, 2'b00, 1'b0); beat(8'h33, 2'b00, 1'b0);
    cyc = 1'b0;
    idle(1);
    @(negedge clk);
    check("cyc_le_cnt", 32'(ifa.d_cnt_o), 32'h3);
    check("cyc_le_sel", 32'(ifa.d_sel_o), 32'h7);
    check("cyc_le_dat", ifa.d_dat_o, 32'h00332211);
    check("cyc_be_sel", 32'(ifb.d_sel_o), 32'hE);
    check("cyc_nf_stb", 32'(ifc.d_stb_o), 32'h0);
    beat(8'h44, 2'b00, 1'b0);
    @(negedge clk);
    check("cyc_nf_dat", ifc.d_dat_o, 32'h44332211);
    check("cyc_nf_cnt", 32'(ifc.d_cnt_o), 32'h4);
    check("cyc_le_idle", 32'(ifa.d_stb_o), 32'h0);

    // reset in the middle of a word
    beat(8'h01, 2'b00, 1'b0); beat(8'h02, 2'b00, 1'b0);
    rst = 1'b1; stb = 1'b1; cyc = 1'b1; dat = 8'hEE;
    @(negedge clk);
    check("mid_rst_ack", 32'(ifa.s_ack_o), 32'h0);
    check("mid_rst_stall", 32'(ifa.s_stall_o), 32'h1);
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_rst_stb", 32'(ifa.d_stb_o), 32'h0);
    check("mid_rst_dat", ifa.d_dat_o, 32'h0);
    check("mid_rst_sel", 32'(ifa.d_sel_o), 32'h0);
    check("mid_rst_cnt", 32'(ifa.d_cnt_o), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0; stb = 1'b0;
    beat(8'h05, 2'b00, 1'b0); beat(8'h06, 2'b00, 1'b0);
    beat(8'h07, 2'b00, 1'b0); beat(8'h08, 2'b00, 1'b0);
    @(negedge clk);
    check("post_rst_le_dat", ifa.d_dat_o, 32'h08070605);
    check("post_rst_le_cnt", 32'(ifa.d_cnt_o), 32'h4);
    check("post_rst_be_dat", ifb.d_dat_o, 32'h05060708);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: stimulus did not complete");
    $fatal(1);
  end
endmodule

`default_nettype wire
